serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract sequencer. Accepts two WIDTH-bit operands on a

---
 rtl/serial_add_ctrl_if.sv | 13 +
 rtl/serial_add_ctrl.sv | 75 +++++++
 tb/tb_serial_add_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand request and result bundle for the bit-serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, sub, a, b, input busy, done, sum, cout);
    modport slave  (input start, sub, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial add/subtract sequencer with a carry flop between steps
module serial_add_ctrl #(parameter int WIDTH = 8) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic             s, maj;
    always_comb begin
        s       = a_q[0] ^ b_q[0] ^ carry_q;
        maj     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.a;
                b_d     = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = maj;
                sum_d   = {s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = maj;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for the bit-serial add/subtract sequencer
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    serial_add_ctrl_if #(.WIDTH(8)) bus ();
    serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        return {1'b0, a} + {1'b0, sub ? ~b : b} + {8'b0, sub};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 50) begin
            step();
            n++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output logic [8:0] got, output int edges, output bit ok);
        exp_q.push_back(model(a, b, sub));
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.sub = ~sub;
        wait_done(edges, ok);
        got = {bus.cout, bus.sum};
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'h000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, required all zero", bus.busy, bus.done, bus.cout, bus.sum);
        end
    endtask
    task automatic test_add_timing();
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        logic [8:0] e;
        exp_q.push_back(model(8'hFF, 8'h01, 1'b0));
        bus.a = 8'hFF;
        bus.b = 8'h01;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i + 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL add_extra_done: done with empty scoreboard, required none");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({bus.cout, bus.sum} !== e || e !== 9'h100) begin
                        errors++;
                        $display("FAIL add_result: got %h required %h", {bus.cout, bus.sum}, e);
                    end
                end
            end
            step();
        end
        checks++;
        if (done_at != 9) begin
            errors++;
            $display("FAIL add_latency: done after %0d edges, required 9", done_at);
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL add_busy_len: busy %0d cycles, required 9", busy_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL add_done_len: done %0d cycles, required 1", done_cnt);
        end
    endtask
    task automatic test_sub();
        logic [8:0] got, e;
        int n;
        bit ok;
        logic [7:0] av[2] = '{8'h5A, 8'h10};
        logic [7:0] bv[2] = '{8'h3C, 8'h20};
        logic [8:0] sv[2] = '{9'h11E, 9'h0F0};
        for (int i = 0; i < 2; i++) begin
            do_op(av[i], bv[i], 1'b1, got, n, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e || got !== sv[i]) begin
                errors++;
                $display("FAIL sub_%0d: got %h done=%b required %h", i, got, ok, sv[i]);
            end
            step();
        end
    endtask
    task automatic test_ignore_busy();
        bit ok = 1'b0;
        logic [8:0] e;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.sub = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!ok || {bus.cout, bus.sum} !== e || e !== 9'h046) begin
            errors++;
            $display("FAIL ignore_busy_result: got %h done=%b required %h", {bus.cout, bus.sum}, ok, e);
        end
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_restart: busy=%b required 0", bus.busy);
        end
    endtask
    task automatic test_back_to_back();
        int ndone = 0;
        int t[2] = '{0, 0};
        logic [8:0] e;
        exp_q.push_back(model(8'h01, 8'h01, 1'b0));
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        bus.a = 8'h01;
        bus.b = 8'h01;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.a = 8'h80;
        bus.b = 8'h80;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                t[ndone] = i;
                e = exp_q.pop_front();
                checks++;
                if ({bus.cout, bus.sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h required %h", ndone, {bus.cout, bus.sum}, e);
                end
                ndone++;
                if (ndone == 2) begin
                    bus.start = 1'b0;
                    break;
                end
            end
            step();
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 2 || t[1] - t[0] != 10) begin
            errors++;
            $display("FAIL b2b_spacing: %0d dones, spacing %0d, required 2 dones 10 apart", ndone, t[1] - t[0]);
        end
        step();
        step();
    endtask
    task automatic test_reset_mid_run();
        int extra = 0;
        logic [8:0] got, e;
        int n;
        bit ok;
        bus.a = 8'h77;
        bus.b = 8'h11;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'h000) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h, required all zero", bus.busy, bus.done, bus.cout, bus.sum);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midrun_no_done: %0d done cycles, required 0", extra);
        end
        do_op(8'h03, 8'h04, 1'b0, got, n, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e || got !== 9'h007) begin
            errors++;
            $display("FAIL midrun_fresh: got %h done=%b required 007", got, ok);
        end
        step();
    endtask
    task automatic test_random();
        logic [8:0] got, e;
        int n;
        bit ok;
        for (int k = 0; k < 500; k++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), got, n, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e || n != 8) begin
                errors++;
                $display("FAIL random_%0d: got %h done=%b edges=%0d required %h edges 8", k, got, ok, n, e);
            end
            for (int j = 0; j < int'($urandom_range(3, 1)); j++) begin
                step();
                checks++;
                if ({bus.cout, bus.sum} !== got) begin
                    errors++;
                    $display("FAIL random_hold_%0d: got %h required %h", k, {bus.cout, bus.sum}, got);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
    endtask
    initial begin
        test_reset();
        test_add_timing();
        test_sub();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
